// File: rtl/lut_seq_pkg.sv
// lut_seq_pkg: shared widths, FSM state type and slot packing helpers for the LUT layer sequencer
package lut_seq_pkg;
  localparam int NUM_IN = 16;
  localparam int IN_BW = 2;
  localparam int FAN_IN = 4;
  localparam int NUM_NEURONS = 8;
  localparam int OUT_BW = 2;
  localparam int AW = FAN_IN * IN_BW;
  localparam int FW = $clog2(NUM_IN);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int SW = $clog2(FAN_IN);
  // one spare bit so an out-of-range feature index is representable and can be rejected
  localparam int DW = OUT_BW > $clog2(NUM_IN + 1) ? OUT_BW : $clog2(NUM_IN + 1);
  typedef enum logic [1:0] {IDLE, EVAL, DRAIN, OUTPUT} state_t;
  function automatic logic [IN_BW-1:0] get_feature(input logic [NUM_IN*IN_BW-1:0] v, input logic [FW-1:0] f);
    return v[f*IN_BW +: IN_BW];
  endfunction
  function automatic logic [NUM_NEURONS*OUT_BW-1:0] put_neuron(input logic [NUM_NEURONS*OUT_BW-1:0] v,
                                                               input logic [NW-1:0] n, input logic [OUT_BW-1:0] d);
    logic [NUM_NEURONS*OUT_BW-1:0] r;
    r = v;
    r[n*OUT_BW +: OUT_BW] = d;
    return r;
  endfunction
endpackage

// File: rtl/lut_seq_mem.sv
// lut_seq_mem: per-neuron truth tables in distributed RAM, synchronous write, registered read
module lut_seq_mem import lut_seq_pkg::*; (
  input  logic              clk,
  input  logic              we,
  input  logic [NW+AW-1:0]  waddr,
  input  logic [OUT_BW-1:0] wdata,
  input  logic [NW+AW-1:0]  raddr,
  output logic [OUT_BW-1:0] rdata
);
  (* ram_style = "distributed" *) logic [OUT_BW-1:0] mem [2**(NW+AW)];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer: evaluates one sparse LUT layer one neuron per cycle from loadable tables
module lut_layer_sequencer import lut_seq_pkg::*; (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic                          cfg_sel,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [AW-1:0]                 cfg_addr,
  input  logic [DW-1:0]                 cfg_data,
  output logic                          cfg_err,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_IN*IN_BW-1:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_NEURONS*OUT_BW-1:0] out_data,
  output logic                          busy
);
  state_t state, next;
  logic [NUM_IN*IN_BW-1:0] in_reg;
  logic [NW-1:0] k;
  logic [FW-1:0] conn [NUM_NEURONS][FAN_IN];
  logic [AW-1:0] addr;
  logic [OUT_BW-1:0] rdata;
  logic accept, cfg_ok, capture;
  assign accept = state == IDLE && in_valid;
  assign cfg_ok = cfg_we && state == IDLE && !in_valid && !(cfg_sel && cfg_data >= DW'(NUM_IN));
  // read data lags the issued neuron by one cycle; k wraps to 0 on the last issue so k-1 hits the last slot in DRAIN
  assign capture = (state == EVAL && k != '0) || state == DRAIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (in_valid) next = EVAL;
      EVAL:    if (k == NW'(NUM_NEURONS - 1)) next = DRAIN;
      DRAIN:   next = OUTPUT;
      OUTPUT:  if (out_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == OUTPUT;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_reg <= '0;
      k <= '0;
      out_data <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (accept) in_reg <= in_data;
      k <= accept ? '0 : state == EVAL ? k + NW'(1) : k;
      if (capture) out_data <= put_neuron(out_data, k - NW'(1), rdata);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++)
        for (int j = 0; j < FAN_IN; j++) conn[n][j] <= FW'(j % NUM_IN);
    end else if (cfg_ok && cfg_sel) conn[cfg_neuron][cfg_addr[SW-1:0]] <= cfg_data[FW-1:0];
  always_comb begin
    addr = '0;
    for (int j = 0; j < FAN_IN; j++) addr[j*IN_BW +: IN_BW] = get_feature(in_reg, conn[k][j]);
  end
  lut_seq_mem mem (
    .clk   (clk),
    .we    (cfg_ok && !cfg_sel),
    .waddr ({cfg_neuron, cfg_addr}),
    .wdata (cfg_data[OUT_BW-1:0]),
    .raddr ({k, addr}),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// tb_lut_layer_sequencer: random and directed checks of the sequencer against a table-lookup model
module tb_lut_layer_sequencer;
  import lut_seq_pkg::*;
  logic clk = 0, rst_n = 0;
  logic cfg_we = 0, cfg_sel = 0;
  logic [NW-1:0] cfg_neuron = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic cfg_err, in_ready, out_valid, busy;
  logic in_valid = 0, out_ready = 1;
  logic [NUM_IN*IN_BW-1:0] in_data = '0;
  logic [NUM_NEURONS*OUT_BW-1:0] out_data;
  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  logic [1:0] lut_m [8][256];
  int conn_m [8][4];

  lut_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input bit sel, input int n, input int a, input int d, input bit upd, output logic err);
    cfg_sel = sel; cfg_neuron = NW'(n); cfg_addr = AW'(a); cfg_data = DW'(d); cfg_we = 1;
    step();
    cfg_we = 0;
    err = cfg_err;
    if (upd && sel) conn_m[n][a] = d;
    else if (upd) lut_m[n][a] = 2'(d);
  endtask

  task automatic start(input logic [31:0] v);
    int t;
    t = 0;
    in_data = v; in_valid = 1;
    while (!in_ready && t < 60) begin step(); t++; end
    step();
    acc_cyc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_out(output logic [15:0] res, output int lat);
    int t;
    t = 0;
    while (!out_valid && t < 60) begin step(); t++; end
    chk("out_valid_seen", out_valid, 1);
    lat = cyc - acc_cyc + 1;
    res = out_data;
    if (out_ready) step();
  endtask

  function automatic logic [15:0] model(input logic [31:0] v);
    logic [15:0] r;
    int a;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      a = 0;
      for (int j = 0; j < 4; j++) a += int'((v >> (2 * conn_m[n][j])) & 32'h3) << (2 * j);
      r[2*n +: 2] = lut_m[n][a];
    end
    return r;
  endfunction

  initial begin
    logic err;
    logic [15:0] res, snap;
    logic [31:0] v;
    int lat, errs, prev, bad, rel;
    for (int n = 0; n < 8; n++) for (int j = 0; j < 4; j++) conn_m[n][j] = j;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1;
    errs = 0;
    for (int n = 0; n < 8; n++)
      for (int a = 0; a < 256; a++) begin cfg(0, n, a, a & 3, 1, err); errs += int'(err); end
    chk("prog_ident_err", errs, 0);
    start(32'h3); wait_out(res, lat);
    chk("ident_model", res, model(32'h3));
    chk("ident_ffff", res, 16'hFFFF);
    chk("ident_latency", lat, 10);
    cfg(1, 3, 0, 15, 1, err);
    chk("remap_err", err, 0);
    start(32'h8000_0000); wait_out(res, lat);
    chk("remap_model", res, model(32'h8000_0000));
    chk("remap_const", res, 16'h0080);
    cfg(1, 3, 0, 0, 1, err);
    chk("restore_err", err, 0);
    start(32'h3); step();
    cfg(1, 0, 0, 5, 0, err);
    chk("err_eval_conn", err, 1);
    cfg(0, 0, 3, 0, 0, err);
    chk("err_eval_lut", err, 1);
    step();
    chk("err_eval_pulse", cfg_err, 0);
    wait_out(res, lat);
    chk("eval_write_dropped", res, 16'hFFFF);
    cfg(1, 2, 0, 16, 0, err);
    chk("err_idx16", err, 1);
    cfg(1, 5, 0, 31, 0, err);
    chk("err_idx31", err, 1);
    step();
    chk("err_idx_pulse", cfg_err, 0);
    in_data = 32'h3; in_valid = 1;
    cfg(0, 1, 3, 0, 0, err);
    in_valid = 0;
    acc_cyc = cyc;
    chk("err_coincident", err, 1);
    chk("coincident_accept", busy, 1);
    wait_out(res, lat);
    chk("coincident_result", res, 16'hFFFF);
    start(32'h3); wait_out(res, lat);
    chk("tables_unchanged", res, model(32'h3));
    start(32'h3); step(); step();
    rst_n = 0;
    step();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1;
    bad = 0;
    repeat (15) begin step(); bad += int'(out_valid); end
    chk("midrst_no_partial", bad, 0);
    start(32'h3); wait_out(res, lat);
    chk("post_rst_result", res, 16'hFFFF);
    out_ready = 0;
    v = $urandom();
    start(v); wait_out(res, lat);
    chk("bp_result", res, model(v));
    snap = out_data;
    v = $urandom();
    in_data = v; in_valid = 1;
    bad = 0;
    repeat (20) begin step(); bad += int'(in_ready || !out_valid || out_data !== snap); end
    chk("bp_stall", bad, 0);
    chk("bp_hold_data", out_data, snap);
    out_ready = 1;
    rel = cyc;
    start(v);
    chk("bp_accept_delay", acc_cyc - rel, 2);
    wait_out(res, lat);
    chk("bp_next_result", res, model(v));
    errs = 0;
    for (int n = 0; n < 8; n++)
      for (int a = 0; a < 256; a++) begin cfg(0, n, a, int'($urandom_range(0, 3)), 1, err); errs += int'(err); end
    for (int n = 0; n < 8; n++)
      for (int j = 0; j < 4; j++) begin cfg(1, n, j, int'($urandom_range(0, 15)), 1, err); errs += int'(err); end
    chk("prog_rand_err", errs, 0);
    prev = 0;
    for (int i = 0; i < 50; i++) begin
      v = $urandom();
      start(v);
      if (i > 0) chk("interval", acc_cyc - prev, 11);
      prev = acc_cyc;
      wait_out(res, lat);
      chk("rand_result", res, model(v));
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
